// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among N_REQ writeback
// sources, with a registered write stage and a pending-write scoreboard for decode.
module regfile_wb_arbiter #(
  parameter int N_REQ  = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*ADDR_W-1:0]   req_reg,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      alloc_valid,
  input  logic [ADDR_W-1:0]         alloc_reg,
  input  logic                      flush,
  output logic                      reg_write,
  output logic [ADDR_W-1:0]         write_reg,
  output logic [DATA_W-1:0]         write_data,
  output logic [31:0]               pending
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     gnt_idx;
  logic              gnt_any;
  logic [N_REQ-1:0]  grant;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;
  logic [31:0]       pend_nxt;

  // Scan rotated from rr_ptr; the first valid requester wins.
  always_comb begin
    int idx;
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    if (!rst) begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= N_REQ) idx = idx - N_REQ;
        if (!gnt_any && req_valid[idx]) begin
          gnt_any    = 1'b1;
          grant[idx] = 1'b1;
          gnt_idx    = PW'(idx);
        end
      end
    end
  end

  assign req_ready = grant;
  assign sel_reg   = req_reg[int'(gnt_idx)*ADDR_W +: ADDR_W];
  assign sel_data  = req_data[int'(gnt_idx)*DATA_W +: DATA_W];

  // Ordering gives alloc precedence over both the writeback clear and flush.
  always_comb begin
    pend_nxt = pending;
    if (gnt_any) pend_nxt[sel_reg] = 1'b0;
    if (flush) pend_nxt = '0;
    if (alloc_valid) pend_nxt[alloc_reg] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      reg_write  <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
      pending    <= '0;
    end else begin
      pending   <= pend_nxt;
      reg_write <= gnt_any && (sel_reg != '0);
      if (gnt_any) begin
        write_reg  <= sel_reg;
        write_data <= sel_data;
        rr_ptr     <= (int'(gnt_idx) == N_REQ-1) ? '0 : gnt_idx + 1'b1;
      end
    end
  end
endmodule
